// File: rtl/branch_rs.sv
// Branch reservation station: holds dispatched branch uops until both operands
// are ready (at dispatch or via CDB wakeup) and issues the oldest ready one.
module branch_rs #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [2:0]       alloc_branch_type,
  input  logic [TAG_W-1:0] alloc_rob_tag,
  input  logic             alloc_rs1_rdy,
  input  logic [TAG_W-1:0] alloc_rs1_tag,
  input  logic [XLEN-1:0]  alloc_rs1_val,
  input  logic             alloc_rs2_rdy,
  input  logic [TAG_W-1:0] alloc_rs2_tag,
  input  logic [XLEN-1:0]  alloc_rs2_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [2:0]       issue_branch_type,
  output logic [XLEN-1:0]  issue_rs1,
  output logic [XLEN-1:0]  issue_rs2,
  output logic [TAG_W-1:0] issue_rob_tag
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] AGE_ONE = AW'(1);

  typedef struct packed {
    logic             vld;
    logic [2:0]       typ;
    logic [TAG_W-1:0] rob;
    logic             rdy1;
    logic [TAG_W-1:0] tag1;
    logic [XLEN-1:0]  val1;
    logic             rdy2;
    logic [TAG_W-1:0] tag2;
    logic [XLEN-1:0]  val2;
    logic [AW-1:0]    age;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [DEPTH-1:0] vld, elig;
  logic [AW-1:0]    free_idx, sel_idx, sel_age;
  logic             any_elig, alloc_fire, issue_fire;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign vld[g]  = ent_q[g].vld;
    assign elig[g] = ent_q[g].vld & ent_q[g].rdy1 & ent_q[g].rdy2;
  end

  assign any_elig    = |elig;
  assign alloc_ready = ~rst & |(~vld);
  assign issue_valid = ~rst & ~flush & any_elig;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign issue_fire  = issue_valid & issue_ready;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!vld[i]) free_idx = AW'(i);
  end

  // Ages are unique among valid entries, so the max-age eligible entry is the oldest.
  always_comb begin
    logic found;
    found   = 1'b0;
    sel_idx = '0;
    sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!found || ent_q[i].age > sel_age)) begin
        found   = 1'b1;
        sel_idx = AW'(i);
        sel_age = ent_q[i].age;
      end
    end
  end

  always_comb begin
    issue_branch_type = '0;
    issue_rs1         = '0;
    issue_rs2         = '0;
    issue_rob_tag     = '0;
    if (!rst && any_elig) begin
      issue_branch_type = ent_q[sel_idx].typ;
      issue_rs1         = ent_q[sel_idx].val1;
      issue_rs2         = ent_q[sel_idx].val2;
      issue_rob_tag     = ent_q[sel_idx].rob;
    end
  end

  always_comb begin
    logic older;
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      older = issue_fire && (ent_q[i].age > sel_age);
      if (ent_q[i].vld) begin
        if (cdb_valid && !ent_q[i].rdy1 && ent_q[i].tag1 == cdb_tag) begin
          ent_d[i].rdy1 = 1'b1;
          ent_d[i].val1 = cdb_data;
        end
        if (cdb_valid && !ent_q[i].rdy2 && ent_q[i].tag2 == cdb_tag) begin
          ent_d[i].rdy2 = 1'b1;
          ent_d[i].val2 = cdb_data;
        end
        if (issue_fire && sel_idx == AW'(i))
          ent_d[i].vld = 1'b0;
        else if (alloc_fire && !older)
          ent_d[i].age = ent_q[i].age + AGE_ONE;
        else if (!alloc_fire && older)
          ent_d[i].age = ent_q[i].age - AGE_ONE;
      end
    end
    // free_idx is never a valid entry, so this cannot collide with the loop above.
    if (alloc_fire) begin
      ent_d[free_idx].vld  = 1'b1;
      ent_d[free_idx].typ  = alloc_branch_type;
      ent_d[free_idx].rob  = alloc_rob_tag;
      ent_d[free_idx].age  = '0;
      ent_d[free_idx].tag1 = alloc_rs1_tag;
      ent_d[free_idx].tag2 = alloc_rs2_tag;
      ent_d[free_idx].rdy1 = alloc_rs1_rdy | (cdb_valid && cdb_tag == alloc_rs1_tag);
      ent_d[free_idx].val1 = alloc_rs1_rdy ? alloc_rs1_val : cdb_data;
      ent_d[free_idx].rdy2 = alloc_rs2_rdy | (cdb_valid && cdb_tag == alloc_rs2_tag);
      ent_d[free_idx].val2 = alloc_rs2_rdy ? alloc_rs2_val : cdb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i].vld <= 1'b0;
    end else begin
      ent_q <= ent_d;
    end
  end

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: expected issues are queued at dispatch and
// compared in order as the RS hands uops to the branch unit.
module tb_branch_rs;
  localparam int XLEN = 32, DEPTH = 4, TAG_W = 6;

  logic             clk = 1'b0, rst = 1'b1;
  logic             alloc_valid = 1'b0, alloc_ready;
  logic [2:0]       alloc_branch_type = '0;
  logic [TAG_W-1:0] alloc_rob_tag = '0, alloc_rs1_tag = '0, alloc_rs2_tag = '0;
  logic             alloc_rs1_rdy = 1'b0, alloc_rs2_rdy = 1'b0;
  logic [XLEN-1:0]  alloc_rs1_val = '0, alloc_rs2_val = '0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [XLEN-1:0]  cdb_data = '0;
  logic             flush = 1'b0, issue_ready = 1'b0, issue_valid;
  logic [2:0]       issue_branch_type;
  logic [XLEN-1:0]  issue_rs1, issue_rs2;
  logic [TAG_W-1:0] issue_rob_tag;

  branch_rs #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_branch_type(alloc_branch_type), .alloc_rob_tag(alloc_rob_tag),
    .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs1_val(alloc_rs1_val),
    .alloc_rs2_rdy(alloc_rs2_rdy), .alloc_rs2_tag(alloc_rs2_tag), .alloc_rs2_val(alloc_rs2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_branch_type(issue_branch_type), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rob_tag(issue_rob_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] rob;
    logic [2:0]       typ;
    logic [XLEN-1:0]  r1, r2;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [TAG_W-1:0] rob, input logic [2:0] typ,
                      input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
    exp_t e;
    e.rob = rob; e.typ = typ; e.r1 = r1; e.r2 = r2;
    exp_q.push_back(e);
  endtask

  task automatic drive_alloc(input logic [2:0] typ, input logic [TAG_W-1:0] rob,
                             input logic r1r, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                             input logic r2r, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
    alloc_valid = 1'b1; alloc_branch_type = typ; alloc_rob_tag = rob;
    alloc_rs1_rdy = r1r; alloc_rs1_tag = t1; alloc_rs1_val = v1;
    alloc_rs2_rdy = r2r; alloc_rs2_tag = t2; alloc_rs2_val = v2;
  endtask

  task automatic alloc(input logic [2:0] typ, input logic [TAG_W-1:0] rob,
                       input logic r1r, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                       input logic r2r, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
    drive_alloc(typ, rob, r1r, t1, v1, r2r, t2, v2);
    tick();
    alloc_valid = 1'b0;
  endtask

  // Sample away from the rising edge; a transfer happens when valid&ready are both up.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue_rob", 64'(issue_rob_tag), 64'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_rob", 64'(issue_rob_tag), 64'(e.rob));
        chk("issue_type", 64'(issue_branch_type), 64'(e.typ));
        chk("issue_rs1", 64'(issue_rs1), 64'(e.r1));
        chk("issue_rs2", 64'(issue_rs2), 64'(e.r2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_rs1", 64'(issue_rs1), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("post_rst_empty", 64'(issue_valid), 64'd0);

    // 1: fully ready alloc issues next cycle
    issue_ready = 1'b1;
    push(6'd10, 3'b000, 32'd5, 32'd5);
    alloc(3'b000, 6'd10, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd5);
    chk("t1_issue_valid", 64'(issue_valid), 64'd1);
    tick();
    chk("t1_empty", 64'(issue_valid), 64'd0);
    chk("t1_drain", 64'(exp_q.size()), 64'd0);

    // 2: CDB wakeup, issue the cycle after broadcast
    push(6'd11, 3'b001, 32'h1234, 32'd9);
    alloc(3'b001, 6'd11, 1'b0, 6'd7, 32'd0, 1'b1, 6'd0, 32'd9);
    tick();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h1234;
    chk("t2_wait", 64'(issue_valid), 64'd0);
    tick();
    cdb_valid = 1'b0;
    chk("t2_issue_valid", 64'(issue_valid), 64'd1);
    tick();
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    // 3: CDB bypass into allocating entry
    push(6'd12, 3'b101, 32'h55, 32'hBEEF);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'hBEEF;
    alloc(3'b101, 6'd12, 1'b1, 6'd0, 32'h55, 1'b0, 6'd3, 32'd0);
    cdb_valid = 1'b0;
    chk("t3_issue_valid", 64'(issue_valid), 64'd1);
    tick();
    chk("t3_drain", 64'(exp_q.size()), 64'd0);

    // 4: fill, hold under backpressure, drain oldest-first
    issue_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      push(6'(k), 3'(k), 32'(k * 16), 32'(k));
      alloc(3'(k), 6'(k), 1'b1, 6'd0, 32'(k * 16), 1'b1, 6'd0, 32'(k));
    end
    chk("t4_full", 64'(alloc_ready), 64'd0);
    drive_alloc(3'b111, 6'd9, 1'b1, 6'd0, 32'd99, 1'b1, 6'd0, 32'd99);
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_rob", 64'(issue_rob_tag), 64'd1);
      chk("t4_hold_rs1", 64'(issue_rs1), 64'd16);
      tick();
    end
    alloc_valid = 1'b0;
    chk("t4_still_full", 64'(alloc_ready), 64'd0);
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t4_empty", 64'(issue_valid), 64'd0);
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // 5: younger ready entry bypasses older waiting one
    issue_ready = 1'b0;
    push(6'd22, 3'b100, 32'd2, 32'd3);
    push(6'd21, 3'b110, 32'h77, 32'd4);
    alloc(3'b110, 6'd21, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd4);
    alloc(3'b100, 6'd22, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd3);
    chk("t5_first_rob", 64'(issue_rob_tag), 64'd22);
    issue_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h77;
    tick();
    cdb_valid = 1'b0;
    chk("t5_second_valid", 64'(issue_valid), 64'd1);
    tick();
    chk("t5_empty", 64'(issue_valid), 64'd0);
    chk("t5_drain", 64'(exp_q.size()), 64'd0);

    // 6a: flush with 3 valid entries; nothing may issue
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      alloc(3'b000, 6'(31 + k), 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k));
    chk("t6_pre_valid", 64'(issue_valid), 64'd1);
    issue_ready = 1'b1;
    flush = 1'b1;
    drive_alloc(3'b000, 6'd34, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd1);
    #1;
    chk("t6_flush_iv", 64'(issue_valid), 64'd0);
    chk("t6_flush_ar", 64'(alloc_ready), 64'd1);
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    #1;
    chk("t6_after_iv", 64'(issue_valid), 64'd0);
    chk("t6_after_ar", 64'(alloc_ready), 64'd1);
    tick();

    // 6b: reset mid-stream
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      alloc(3'b001, 6'(41 + k), 1'b1, 6'd0, 32'(k + 7), 1'b1, 6'd0, 32'(k));
    issue_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_iv", 64'(issue_valid), 64'd0);
    chk("t6_rst_ar", 64'(alloc_ready), 64'd0);
    chk("t6_rst_rs1", 64'(issue_rs1), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_rst_after_iv", 64'(issue_valid), 64'd0);
    chk("t6_rst_after_ar", 64'(alloc_ready), 64'd1);
    tick();
    chk("t6_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
